// File: rtl/sprite_fetch_renderer.sv
// sprite_fetch_renderer
//
// Read-side client of the 1-bit sprite bitmap store. On an accepted request
// it walks one sprite's N = SPRITE_WIDTH*SPRITE_HEIGHT pixels through the
// store's read port, caches them in a local bitmap, and then flags every
// raster position that falls on a set pixel of the sprite's screen box.
// One instance sits in front of the VGA pixel mux for each on-screen sprite.
//
// Optional feature macro: SFR_DOUBLE_BUF_EN
//   defined   - fetch fills a back bitmap/position; the front copy keeps
//               rendering and is replaced in one edge when the walk ends.
//   undefined - single bitmap; the sprite is blanked while it is refetched.
//
// Ports
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   load_valid    request to fetch a sprite
//   load_ready    block can accept a request (low while fetching)
//   load_sprite   sprite index to fetch (clamped to NUM_SPRITES-1)
//   pos_x, pos_y  screen position of the sprite's top-left, sampled on accept
//   rd_addr       registered read address to the sprite store
//   rd_data       store read data, valid one cycle after rd_addr
//   hcount        current raster x
//   vcount        current raster y
//   sprite_valid  cached bitmap is complete and displayable
//   pixel_on      registered: sprite pixel set at previous cycle's raster point
module sprite_fetch_renderer #(
    parameter int SPRITE_WIDTH  = 8,
    parameter int SPRITE_HEIGHT = 8,
    parameter int NUM_SPRITES   = 8,
    parameter int X_W           = 10,
    parameter int Y_W           = 10,
    parameter int SCALE_SHIFT   = 0,
    parameter int ADDR_W        = $clog2(NUM_SPRITES * SPRITE_WIDTH * SPRITE_HEIGHT),
    parameter int IDX_W         = $clog2(NUM_SPRITES)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [IDX_W-1:0]  load_sprite,
    input  logic [X_W-1:0]    pos_x,
    input  logic [Y_W-1:0]    pos_y,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_data,
    input  logic [X_W-1:0]    hcount,
    input  logic [Y_W-1:0]    vcount,
    output logic              sprite_valid,
    output logic              pixel_on
);

    localparam int N     = SPRITE_WIDTH * SPRITE_HEIGHT;
    localparam int BIT_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = $clog2(N + 1);
    localparam int BOX_W = SPRITE_WIDTH << SCALE_SHIFT;
    localparam int BOX_H = SPRITE_HEIGHT << SCALE_SHIFT;

    typedef enum logic [1:0] {IDLE, FETCH, READY} state_t;

    state_t           state;
    logic [CNT_W-1:0] cyc;
    logic [N-1:0]     front_map;
    logic [X_W-1:0]   front_x;
    logic [Y_W-1:0]   front_y;
`ifdef SFR_DOUBLE_BUF_EN
    logic [N-1:0]     back_map;
    logic [X_W-1:0]   back_x;
    logic [Y_W-1:0]   back_y;
`endif

    logic              accept;
    logic [31:0]       spr_i;
    logic [ADDR_W-1:0] base;
    logic [BIT_W-1:0]  cap_idx;
    logic [N-1:0]      fill_map;
    logic [N-1:0]      fill_next;
    logic              render_en;
    logic [X_W:0]      dx;
    logic [Y_W:0]      dy;
    logic [31:0]       col_i;
    logic [31:0]       row_i;
    logic [BIT_W-1:0]  pix_sel;
    logic              in_box;

    assign accept = load_valid && load_ready;

    // Out-of-range indices are clamped so the walk never leaves the store.
    always_comb begin
        spr_i = 32'(load_sprite);
        if (spr_i >= 32'(NUM_SPRITES)) begin
            spr_i = 32'(NUM_SPRITES - 1);
        end
        base = ADDR_W'(spr_i * 32'(N));
    end

    // cyc counts fetch edges; the capture of bit j happens when cyc == j+1,
    // two edges behind the address that produced it (store read latency).
    assign cap_idx = BIT_W'(cyc - CNT_W'(1));

`ifdef SFR_DOUBLE_BUF_EN
    assign fill_map  = back_map;
    assign render_en = sprite_valid;
`else
    assign fill_map  = front_map;
    // Blank from the accept edge itself so no old pixel leaks into the fetch.
    assign render_en = sprite_valid && !accept;
`endif

    always_comb begin
        fill_next          = fill_map;
        fill_next[cap_idx] = rd_data;
    end

    // Fetch controller: address walk, bitmap capture and handshake flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            load_ready   <= 1'b1;
            sprite_valid <= 1'b0;
            rd_addr      <= '0;
            cyc          <= '0;
            front_map    <= '0;
            front_x      <= '0;
            front_y      <= '0;
`ifdef SFR_DOUBLE_BUF_EN
            back_map     <= '0;
            back_x       <= '0;
            back_y       <= '0;
`endif
        end else begin
            case (state)
                IDLE, READY: begin
                    if (accept) begin
                        state      <= FETCH;
                        load_ready <= 1'b0;
                        rd_addr    <= base;
                        cyc        <= '0;
`ifdef SFR_DOUBLE_BUF_EN
                        back_x     <= pos_x;
                        back_y     <= pos_y;
`else
                        sprite_valid <= 1'b0;
                        front_x      <= pos_x;
                        front_y      <= pos_y;
`endif
                    end
                end
                FETCH: begin
                    cyc <= cyc + CNT_W'(1);
                    if (cyc < CNT_W'(N - 1)) begin
                        rd_addr <= rd_addr + ADDR_W'(1);
                    end
                    if (cyc != '0) begin
`ifdef SFR_DOUBLE_BUF_EN
                        back_map <= fill_next;
`else
                        front_map <= fill_next;
`endif
                    end
                    if (cyc == CNT_W'(N)) begin
                        state        <= READY;
                        load_ready   <= 1'b1;
                        sprite_valid <= 1'b1;
`ifdef SFR_DOUBLE_BUF_EN
                        // Swap uses fill_next so the final captured bit lands too.
                        front_map <= fill_next;
                        front_x   <= back_x;
                        front_y   <= back_y;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Offsets are one bit wider than the raster so a box hanging off the
    // right/bottom edge is clipped instead of wrapping back to column/row 0.
    always_comb begin
        dx      = {1'b0, hcount} - {1'b0, front_x};
        dy      = {1'b0, vcount} - {1'b0, front_y};
        in_box  = (hcount >= front_x) && (vcount >= front_y) &&
                  (32'(dx) < 32'(BOX_W)) && (32'(dy) < 32'(BOX_H));
        col_i   = 32'(dx >> SCALE_SHIFT);
        row_i   = 32'(dy >> SCALE_SHIFT);
        pix_sel = BIT_W'(row_i * 32'(SPRITE_WIDTH) + col_i);
    end

    // One-cycle render pipeline.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pixel_on <= 1'b0;
        end else begin
            pixel_on <= render_en && in_box && front_map[pix_sel];
        end
    end

endmodule

// File: tb/tb_sprite_fetch_renderer.sv
// Testbench for sprite_fetch_renderer.
// Two instances share the clock, reset and raster: "dut" (SCALE_SHIFT=0,
// 4-bit sprite index so out-of-range indices can be requested) and "dut_s"
// (SCALE_SHIFT=1). A synchronous 512x1 store model feeds each read port.
// Store contents: sprite s, row r is the byte C7 ^ (r*17) ^ (s*8), bit c = column c.
module tb_sprite_fetch_renderer;

`ifdef SFR_DOUBLE_BUF_EN
    localparam logic DBL = 1'b1;
`else
    localparam logic DBL = 1'b0;
`endif

    typedef struct packed {
        logic [2:0] phase;
        logic [9:0] h;
        logic [9:0] v;
        logic       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       load_valid, load_valid_s;
    logic [3:0] load_sprite;
    logic [2:0] load_sprite_s;
    logic [9:0] pos_x, pos_y, hcount, vcount;
    logic [8:0] rd_addr, rd_addr_s;
    logic       rd_data, rd_data_s;
    logic       load_ready, load_ready_s;
    logic       sprite_valid, sprite_valid_s;
    logic       pixel_on, pixel_on_s;
    logic       mem [0:511];
    vec_t       vecs [$];
    int         checks = 0;
    int         errors = 0;

    sprite_fetch_renderer #(.SCALE_SHIFT(0), .IDX_W(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .load_valid(load_valid), .load_ready(load_ready), .load_sprite(load_sprite),
        .pos_x(pos_x), .pos_y(pos_y),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .hcount(hcount), .vcount(vcount),
        .sprite_valid(sprite_valid), .pixel_on(pixel_on)
    );

    sprite_fetch_renderer #(.SCALE_SHIFT(1)) dut_s (
        .clk(clk), .reset_n(reset_n),
        .load_valid(load_valid_s), .load_ready(load_ready_s), .load_sprite(load_sprite_s),
        .pos_x(pos_x), .pos_y(pos_y),
        .rd_addr(rd_addr_s), .rd_data(rd_data_s),
        .hcount(hcount), .vcount(vcount),
        .sprite_valid(sprite_valid_s), .pixel_on(pixel_on_s)
    );

    always #5 clk = ~clk;

    // Synchronous store: data for an address appears one clock later.
    always @(posedge clk) begin
        rd_data   <= mem[rd_addr];
        rd_data_s <= mem[rd_addr_s];
    end

    function automatic logic [7:0] rowByte(input int s, input int r);
        return 8'hC7 ^ 8'(r * 17) ^ 8'(s * 8);
    endfunction

    function automatic vec_t mk(input int p, input int h, input int v, input logic e);
        vec_t t;
        t.phase = 3'(p);
        t.h     = 10'(h);
        t.v     = 10'(v);
        t.exp   = e;
        return t;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Drive a raster point at a negedge and advance to the next negedge.
    task automatic applyStimulus(input logic [9:0] h, input logic [9:0] v);
        hcount = h;
        vcount = v;
        @(negedge clk);
    endtask

    task automatic runTable(input int phase);
        for (int i = 0; i < vecs.size(); i++) begin
            if (int'(vecs[i].phase) == phase) begin
                applyStimulus(vecs[i].h, vecs[i].v);
                if (phase == 0)
                    checkOutput($sformatf("p%0d_pix_h%0d_v%0d", phase, vecs[i].h, vecs[i].v),
                                32'(pixel_on_s), 32'(vecs[i].exp));
                else
                    checkOutput($sformatf("p%0d_pix_h%0d_v%0d", phase, vecs[i].h, vecs[i].v),
                                32'(pixel_on), 32'(vecs[i].exp));
            end
        end
    endtask

    // Request a fetch on dut and follow it edge by edge: address walk,
    // busy flag, completion exactly 65 edges after accept, and the
    // render output held at (h,v) throughout.
    task automatic fetchSprite(input int spr, input int x, input int y, input int expBase,
                               input logic [9:0] h, input logic [9:0] v,
                               input logic expPix, input logic expValid);
        hcount      = h;
        vcount      = v;
        load_sprite = 4'(spr);
        pos_x       = 10'(x);
        pos_y       = 10'(y);
        load_valid  = 1'b1;
        @(negedge clk);
        load_valid  = 1'b0;
        for (int k = 0; k <= 65; k++) begin
            if (k <= 63)
                checkOutput($sformatf("s%0d_walk_addr_k%0d", spr, k), 32'(rd_addr), 32'(expBase + k));
            if (k <= 64) begin
                checkOutput($sformatf("s%0d_busy_ready_k%0d", spr, k), 32'(load_ready), 32'(0));
                checkOutput($sformatf("s%0d_busy_valid_k%0d", spr, k), 32'(sprite_valid), 32'(expValid));
            end else begin
                checkOutput($sformatf("s%0d_done_valid", spr), 32'(sprite_valid), 32'(1));
                checkOutput($sformatf("s%0d_done_ready", spr), 32'(load_ready), 32'(1));
                checkOutput($sformatf("s%0d_done_addr", spr), 32'(rd_addr), 32'(expBase + 63));
            end
            checkOutput($sformatf("s%0d_fetch_pix_k%0d", spr, k), 32'(pixel_on), 32'(expPix));
            if (k < 65) @(negedge clk);
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] rb;
        int         cnt;

        for (int a = 0; a < 512; a++) begin
            rb     = rowByte(a / 64, (a / 8) % 8);
            mem[a] = rb[a % 8];
        end

        // phase 0: scaled sprite 5 at (0,0)
        vecs.push_back(mk(0, 4, 0, 1));  vecs.push_back(mk(0, 5, 0, 1));
        vecs.push_back(mk(0, 4, 1, 1));  vecs.push_back(mk(0, 5, 1, 1));
        vecs.push_back(mk(0, 16, 0, 0)); vecs.push_back(mk(0, 8, 0, 0));
        vecs.push_back(mk(0, 9, 1, 0));  vecs.push_back(mk(0, 14, 0, 1));
        vecs.push_back(mk(0, 15, 1, 1)); vecs.push_back(mk(0, 0, 2, 0));
        vecs.push_back(mk(0, 2, 3, 1));  vecs.push_back(mk(0, 0, 16, 0));
        vecs.push_back(mk(0, 15, 15, 1));
        // phase 1: sprite 0 at (100,50)
        vecs.push_back(mk(1, 99, 50, 0));  vecs.push_back(mk(1, 100, 50, 1));
        vecs.push_back(mk(1, 101, 50, 1)); vecs.push_back(mk(1, 102, 50, 1));
        vecs.push_back(mk(1, 103, 50, 0)); vecs.push_back(mk(1, 104, 50, 0));
        vecs.push_back(mk(1, 105, 50, 0)); vecs.push_back(mk(1, 106, 50, 1));
        vecs.push_back(mk(1, 107, 50, 1)); vecs.push_back(mk(1, 108, 50, 0));
        vecs.push_back(mk(1, 100, 49, 0)); vecs.push_back(mk(1, 106, 49, 0));
        vecs.push_back(mk(1, 100, 58, 0)); vecs.push_back(mk(1, 101, 58, 0));
        vecs.push_back(mk(1, 104, 57, 1)); vecs.push_back(mk(1, 106, 57, 0));
        vecs.push_back(mk(1, 107, 57, 1)); vecs.push_back(mk(1, 100, 57, 0));
        vecs.push_back(mk(1, 100, 51, 0)); vecs.push_back(mk(1, 101, 51, 1));
        vecs.push_back(mk(1, 104, 51, 1));
        // phase 2: sprite 1 at (200,50) after reload
        vecs.push_back(mk(2, 101, 50, 0)); vecs.push_back(mk(2, 200, 50, 1));
        vecs.push_back(mk(2, 203, 50, 1)); vecs.push_back(mk(2, 204, 50, 0));
        vecs.push_back(mk(2, 205, 50, 0)); vecs.push_back(mk(2, 206, 50, 1));
        vecs.push_back(mk(2, 207, 50, 1)); vecs.push_back(mk(2, 208, 50, 0));
        vecs.push_back(mk(2, 199, 50, 0));
        // phase 3: index 9 clamped to sprite 7 at (1020,1020), clipped box
        vecs.push_back(mk(3, 1020, 1020, 1)); vecs.push_back(mk(3, 1023, 1020, 1));
        vecs.push_back(mk(3, 0, 1020, 0));    vecs.push_back(mk(3, 3, 1020, 0));
        vecs.push_back(mk(3, 1020, 0, 0));    vecs.push_back(mk(3, 1021, 2, 0));
        vecs.push_back(mk(3, 1020, 1021, 0)); vecs.push_back(mk(3, 1021, 1021, 1));
        vecs.push_back(mk(3, 1023, 1023, 1)); vecs.push_back(mk(3, 1019, 1020, 0));
        // phase 4: sprite 2 at (10,10) refetched after a mid-fetch reset
        vecs.push_back(mk(4, 10, 10, 1)); vecs.push_back(mk(4, 13, 10, 0));
        vecs.push_back(mk(4, 14, 10, 1)); vecs.push_back(mk(4, 15, 10, 0));
        vecs.push_back(mk(4, 9, 10, 0));

        reset_n       = 1'b0;
        load_valid    = 1'b0;
        load_valid_s  = 1'b0;
        load_sprite   = '0;
        load_sprite_s = '0;
        pos_x         = '0;
        pos_y         = '0;
        hcount        = '0;
        vcount        = '0;
        repeat (2) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_load_ready", 32'(load_ready), 32'(1));
        checkOutput("rst_sprite_valid", 32'(sprite_valid), 32'(0));
        checkOutput("rst_pixel_on", 32'(pixel_on), 32'(0));
        checkOutput("rst_rd_addr", 32'(rd_addr), 32'(0));
        checkOutput("rst_s_load_ready", 32'(load_ready_s), 32'(1));
        checkOutput("rst_s_sprite_valid", 32'(sprite_valid_s), 32'(0));
        reset_n = 1'b1;
        @(negedge clk);

        $display("[TB] scaled sprite 5 at (0,0)");
        load_sprite_s = 3'd5;
        pos_x         = '0;
        pos_y         = '0;
        load_valid_s  = 1'b1;
        @(negedge clk);
        load_valid_s  = 1'b0;
        cnt = 0;
        while (sprite_valid_s !== 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("scaled_latency", 32'(cnt), 32'(65));
        checkOutput("scaled_final_addr", 32'(rd_addr_s), 32'(5 * 64 + 63));
        runTable(0);

        $display("[TB] load sprite 0 at (100,50)");
        fetchSprite(0, 100, 50, 0, 10'd100, 10'd50, 1'b0, 1'b0);
        runTable(1);

        $display("[TB] reload sprite 1 at (200,50)");
        applyStimulus(10'd101, 10'd50);
        checkOutput("pre_reload_pix", 32'(pixel_on), 32'(1));
        fetchSprite(1, 200, 50, 64, 10'd101, 10'd50, DBL, DBL);
        runTable(2);

        $display("[TB] out-of-range index 9 at (1020,1020)");
        fetchSprite(9, 1020, 1020, 448, 10'd200, 10'd50, DBL, DBL);
        runTable(3);

        $display("[TB] reset during fetch of sprite 2");
        hcount      = 10'd1020;
        vcount      = 10'd1020;
        load_sprite = 4'd2;
        pos_x       = 10'd10;
        pos_y       = 10'd10;
        load_valid  = 1'b1;
        @(negedge clk);
        load_valid  = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("midfetch_addr", 32'(rd_addr), 32'(128 + 30));
        checkOutput("midfetch_ready", 32'(load_ready), 32'(0));
        checkOutput("midfetch_valid", 32'(sprite_valid), 32'(DBL));
        checkOutput("midfetch_pix", 32'(pixel_on), 32'(DBL));
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_ready", 32'(load_ready), 32'(1));
        checkOutput("async_rst_valid", 32'(sprite_valid), 32'(0));
        checkOutput("async_rst_pix", 32'(pixel_on), 32'(0));
        checkOutput("async_rst_addr", 32'(rd_addr), 32'(0));
        #2;
        reset_n = 1'b1;
        @(negedge clk);
        fetchSprite(2, 10, 10, 128, 10'd10, 10'd10, 1'b0, 1'b0);
        runTable(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
